// File: rtl/cmd_arbiter.sv
// rtl/cmd_arbiter.sv - two-requester arbiter for the cmd_proc command port
module cmd_arbiter #(
  parameter bit UART_PRIO = 1'b1,
  parameter int TO_W      = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_UART,
  input  logic [15:0] cmd_tour,
  input  logic        cmd_rdy_tour,
  output logic        clr_tour,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        send_resp_UART,
  output logic [7:0]  resp,
  output logic [1:0]  owner,
  output logic        err_to
);

  typedef enum logic [1:0] {IDLE, GNT, BUSY} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_UART = 2'b01;
  localparam logic [1:0] OWN_TOUR = 2'b10;
  localparam logic [7:0] RESP_UART = 8'hA5;
  localparam logic [7:0] RESP_TOUR = 8'h5A;
  localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [15:0]     cmd_q, cmd_d;
  logic [1:0]      owner_q, owner_d;
  logic            last_tour_q, last_tour_d;
  logic            err_to_q, err_to_d;
  logic            pulse_q, pulse_d;
  logic [7:0]      resp_q, resp_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic            pick_uart;
  logic            done;
  logic [TO_W-1:0] cnt_inc;

  // State register; reset abandons any command in flight without an ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= 16'h0000;
      owner_q     <= OWN_NONE;
      last_tour_q <= 1'b1;
      err_to_q    <= 1'b0;
      pulse_q     <= 1'b0;
      resp_q      <= RESP_UART;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      owner_q     <= owner_d;
      last_tour_q <= last_tour_d;
      err_to_q    <= err_to_d;
      pulse_q     <= pulse_d;
      resp_q      <= resp_d;
      cnt_q       <= cnt_d;
    end
  end

  // Arbitration, grant/complete/timeout sequencing
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    owner_d     = owner_q;
    last_tour_d = last_tour_q;
    err_to_d    = err_to_q;
    pulse_d     = 1'b0;
    resp_d      = resp_q;
    cnt_d       = cnt_q;
    pick_uart   = 1'b0;
    done        = 1'b0;
    cnt_inc     = cnt_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On a tie, round-robin favours whoever did not own the port last
        if (cmd_rdy_UART && cmd_rdy_tour) pick_uart = UART_PRIO ? 1'b1 : last_tour_q;
        else                              pick_uart = cmd_rdy_UART;
        if (cmd_rdy_UART || cmd_rdy_tour) begin
          state_d     = GNT;
          owner_d     = pick_uart ? OWN_UART : OWN_TOUR;
          last_tour_d = ~pick_uart;
          cmd_d       = pick_uart ? cmd_UART : cmd_tour;
          err_to_d    = 1'b0;
        end
      end
      GNT, BUSY: begin
        cnt_d = cnt_inc;
        // A completion arriving together with the consume in GNT finishes the command
        done  = send_resp && ((state_q == BUSY) || clr_cmd_rdy);
        if (done) begin
          state_d = IDLE;
          pulse_d = 1'b1;
          resp_d  = (owner_q == OWN_UART) ? RESP_UART : RESP_TOUR;
          owner_d = OWN_NONE;
          cnt_d   = '0;
        end else if (&cnt_inc) begin
          state_d  = IDLE;
          owner_d  = OWN_NONE;
          err_to_d = 1'b1;
          cnt_d    = '0;
        end else if ((state_q == GNT) && clr_cmd_rdy) begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Acknowledge goes back only to the current owner, only while the command is offered
  always_comb begin
    cmd_rdy  = (state_q == GNT);
    clr_UART = clr_cmd_rdy && (state_q == GNT) && (owner_q == OWN_UART);
    clr_tour = clr_cmd_rdy && (state_q == GNT) && (owner_q == OWN_TOUR);
  end

  assign cmd            = cmd_q;
  assign owner          = owner_q;
  assign err_to         = err_to_q;
  assign send_resp_UART = pulse_q;
  assign resp           = resp_q;

endmodule
